// File: rtl/conv_mac_pipe_if.sv
// Stream and weight-port bundle for conv_mac_pipe.
//   slave  : the MAC pipeline's view (consumes beats/writes, produces results)
//   master : the driver's view
// Signals:
//   in_valid/in_ready/in_pix       window beat handshake, tap t at [t*DW +: DW]
//   w_wr_en/w_wr_ch/w_wr_idx/w_wr_data  weight/bias write port (idx==TAPS is the bias)
//   out_valid/out_ready/out_data   result handshake, channel c at [c*OW +: OW]
interface conv_mac_pipe_if #(
    parameter int KSIZE = 5,
    parameter int NCH   = 3,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 12
);
    localparam int TAPS = KSIZE * KSIZE;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IDXW = $clog2(TAPS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [TAPS*DW-1:0]    in_pix;
    logic                  w_wr_en;
    logic [CHW-1:0]        w_wr_ch;
    logic [IDXW-1:0]       w_wr_idx;
    logic [WW-1:0]         w_wr_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*OW-1:0]     out_data;

    modport slave (
        input  in_valid, in_pix, w_wr_en, w_wr_ch, w_wr_idx, w_wr_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_pix, w_wr_en, w_wr_ch, w_wr_idx, w_wr_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv_mac_pipe.sv
// Pipelined multi-channel convolution MAC.
// One KSIZE x KSIZE unsigned pixel window per accepted beat yields NCH signed
// outputs: sat((dot(window, kernel_c) >>> SHIFT) + bias_c), optionally ReLU'd.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears pipeline, weights and biases)
//   bus  conv_mac_pipe_if slave: input beats, weight writes, result stream
// Three register stages (products+bias, sums+bias, saturated result) advance
// together whenever the output register is empty or being drained.
module conv_mac_pipe #(
    parameter int KSIZE = 5,
    parameter int NCH   = 3,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int SHIFT = 8,
    parameter int OW    = 12,
    parameter int RELU  = 0
) (
    input  logic           clk,
    input  logic           rst,
    conv_mac_pipe_if.slave bus
);
    localparam int TAPS = KSIZE * KSIZE;
    localparam int PW   = DW + WW + 1;
    localparam int ACCW = PW + $clog2(TAPS);
    localparam int RW   = ACCW + 1;
    localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (OW - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (OW - 1)));

    logic signed [WW-1:0]   w_q     [NCH][TAPS];
    logic signed [WW-1:0]   w_d     [NCH][TAPS];
    logic signed [WW-1:0]   b_q     [NCH];
    logic signed [WW-1:0]   b_d     [NCH];
    logic signed [PW-1:0]   prod_q  [NCH][TAPS];
    logic signed [PW-1:0]   prod_d  [NCH][TAPS];
    logic signed [WW-1:0]   bias1_q [NCH];
    logic signed [WW-1:0]   bias1_d [NCH];
    logic signed [ACCW-1:0] sum_q   [NCH];
    logic signed [ACCW-1:0] sum_d   [NCH];
    logic signed [WW-1:0]   bias2_q [NCH];
    logic signed [WW-1:0]   bias2_d [NCH];
    logic                   v1_q, v1_d, v2_q, v2_d;
    logic                   out_valid_q, out_valid_d;
    logic [NCH*OW-1:0]      out_data_q, out_data_d;

    logic                   en, accept, wr_ok;
    logic signed [ACCW-1:0] acc;
    logic signed [RW-1:0]   res;

    always_comb begin
        en     = !out_valid_q || bus.out_ready;
        accept = bus.in_valid && en && !rst;
    end

    assign bus.in_ready  = en && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Weight/bias file; out-of-range channel or index writes are dropped.
    always_comb begin
        w_d   = w_q;
        b_d   = b_q;
        wr_ok = bus.w_wr_en && (int'(bus.w_wr_ch) < NCH) && (int'(bus.w_wr_idx) <= TAPS);
        for (int c = 0; c < NCH; c++) begin
            if (wr_ok && int'(bus.w_wr_ch) == c) begin
                if (int'(bus.w_wr_idx) == TAPS) b_d[c] = bus.w_wr_data;
                for (int t = 0; t < TAPS; t++) begin
                    if (int'(bus.w_wr_idx) == t) w_d[c][t] = bus.w_wr_data;
                end
            end
        end
    end

    // Bias travels with the products so later writes cannot touch in-flight beats.
    always_comb begin
        prod_d      = prod_q;
        bias1_d     = bias1_q;
        v1_d        = v1_q;
        sum_d       = sum_q;
        bias2_d     = bias2_q;
        v2_d        = v2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc         = '0;
        res         = '0;
        if (en) begin
            v1_d = accept;
            for (int c = 0; c < NCH; c++) begin
                bias1_d[c] = b_q[c];
                for (int t = 0; t < TAPS; t++) begin
                    prod_d[c][t] = PW'($signed({1'b0, bus.in_pix[t*DW +: DW]})) * PW'(w_q[c][t]);
                end
            end

            v2_d = v1_q;
            for (int c = 0; c < NCH; c++) begin
                acc = '0;
                for (int t = 0; t < TAPS; t++) begin
                    acc = acc + ACCW'(prod_q[c][t]);
                end
                sum_d[c]   = acc;
                bias2_d[c] = bias1_q[c];
            end

            out_valid_d = v2_q;
            for (int c = 0; c < NCH; c++) begin
                // Arithmetic shift on a signed value floors toward -inf.
                res = RW'(sum_q[c] >>> SHIFT) + RW'(bias2_q[c]);
                if (res > SAT_MAX)      res = SAT_MAX;
                else if (res < SAT_MIN) res = SAT_MIN;
                if (RELU != 0 && res < 0) res = '0;
                out_data_d[c*OW +: OW] = res[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                b_q[c]     <= '0;
                bias1_q[c] <= '0;
                bias2_q[c] <= '0;
                sum_q[c]   <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    w_q[c][t]    <= '0;
                    prod_q[c][t] <= '0;
                end
            end
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            w_q         <= w_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            bias1_q     <= bias1_d;
            v1_q        <= v1_d;
            sum_q       <= sum_d;
            bias2_q     <= bias2_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Self-checking bench for conv_mac_pipe. Two instances (RELU=0 and RELU=1)
// share identical stimulus; a plain-arithmetic model predicts each result.
module tb_conv_mac_pipe;
    localparam int KSIZE = 5;
    localparam int NCH   = 3;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int SHIFT = 8;
    localparam int OW    = 12;
    localparam int TAPS  = KSIZE * KSIZE;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IDXW  = $clog2(TAPS + 1);

    typedef logic [TAPS*DW-1:0] pix_t;
    typedef logic [NCH*OW-1:0]  res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_mac_pipe_if #(.KSIZE(KSIZE), .NCH(NCH), .DW(DW), .WW(WW), .OW(OW)) bus ();
    conv_mac_pipe_if #(.KSIZE(KSIZE), .NCH(NCH), .DW(DW), .WW(WW), .OW(OW)) bus_r ();

    assign bus_r.in_valid  = bus.in_valid;
    assign bus_r.in_pix    = bus.in_pix;
    assign bus_r.w_wr_en   = bus.w_wr_en;
    assign bus_r.w_wr_ch   = bus.w_wr_ch;
    assign bus_r.w_wr_idx  = bus.w_wr_idx;
    assign bus_r.w_wr_data = bus.w_wr_data;
    assign bus_r.out_ready = bus.out_ready;

    conv_mac_pipe #(.KSIZE(KSIZE), .NCH(NCH), .DW(DW), .WW(WW), .SHIFT(SHIFT), .OW(OW), .RELU(0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    conv_mac_pipe #(.KSIZE(KSIZE), .NCH(NCH), .DW(DW), .WW(WW), .SHIFT(SHIFT), .OW(OW), .RELU(1))
        dut_r (.clk(clk), .rst(rst), .bus(bus_r));

    int   n_checks = 0;
    int   n_errors = 0;
    int   wm [NCH][TAPS+1];
    res_t exp_q[$], exp_r_q[$], obs_q[$], obs_r_q[$];
    bit   hold = 1'b0;
    res_t hold_data;
    bit   last_acc;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ch_of(input res_t d, input int c);
        logic signed [OW-1:0] v;
        v = d[c*OW +: OW];
        return longint'(v);
    endfunction

    function automatic res_t model(input pix_t pix, input bit relu);
        res_t   r;
        longint s, q, v;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            s = 0;
            for (int t = 0; t < TAPS; t++) s += longint'(pix[t*DW +: DW]) * longint'(wm[c][t]);
            q = s / (64'sd1 << SHIFT);
            if (s < 0 && (s % (64'sd1 << SHIFT)) != 0) q -= 1;
            v = q + longint'(wm[c][TAPS]);
            if (v > (2 ** (OW - 1)) - 1) v = (2 ** (OW - 1)) - 1;
            if (v < -(2 ** (OW - 1)))    v = -(2 ** (OW - 1));
            if (relu && v < 0) v = 0;
            r[c*OW +: OW] = OW'(v);
        end
        return r;
    endfunction

    function automatic pix_t pix_all(input int v);
        pix_t p;
        for (int t = 0; t < TAPS; t++) p[t*DW +: DW] = DW'(v);
        return p;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, update model.
    task automatic cycle(input bit v, input pix_t pix, input bit ordy,
                         input bit we, input int ch, input int idx, input int data);
        res_t e, er;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pix    = pix;
        bus.out_ready = ordy;
        bus.w_wr_en   = we;
        bus.w_wr_ch   = CHW'(ch);
        bus.w_wr_idx  = IDXW'(idx);
        bus.w_wr_data = WW'(data);
        #1;
        last_acc = bus.in_valid && bus.in_ready;
        if (hold) begin
            chk("stall_valid", longint'(bus.out_valid), 1);
            chk("stall_data", longint'(bus.out_data), longint'(hold_data));
        end
        chk("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || ordy));
        chk("relu_valid_match", longint'(bus_r.out_valid), longint'(bus.out_valid));
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", longint'(exp_q.size()), 1);
            end else begin
                e  = exp_q.pop_front();
                er = exp_r_q.pop_front();
                obs_q.push_back(bus.out_data);
                obs_r_q.push_back(bus_r.out_data);
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("out_ch%0d", c), ch_of(bus.out_data, c), ch_of(e, c));
                    chk($sformatf("relu_ch%0d", c), ch_of(bus_r.out_data, c), ch_of(er, c));
                end
            end
        end
        hold      = bus.out_valid && !ordy;
        hold_data = bus.out_data;
        if (last_acc) begin
            exp_q.push_back(model(pix, 1'b0));
            exp_r_q.push_back(model(pix, 1'b1));
        end
        if (we && ch >= 0 && ch < NCH && idx >= 0 && idx <= TAPS)
            wm[ch][idx] = int'($signed(WW'(data)));
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int idx, input int data);
        cycle(1'b0, '0, 1'b1, 1'b1, ch, idx, data);
    endtask

    task automatic load_all(input int w, input int b);
        for (int c = 0; c < NCH; c++) begin
            for (int t = 0; t < TAPS; t++) wr(c, t, w);
            wr(c, TAPS, b);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        chk("drain_empty", longint'(exp_q.size()), 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.w_wr_en   = 1'b1;
            bus.w_wr_ch   = '0;
            bus.w_wr_idx  = '0;
            bus.w_wr_data = 8'd77;
            #1;
            chk("rst_in_ready", longint'(bus.in_ready), 0);
        end
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t <= TAPS; t++) wm[c][t] = 0;
        exp_q.delete();
        exp_r_q.delete();
        hold = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.w_wr_en  = 1'b0;
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_relu_data", longint'(bus_r.out_data), 0);
    endtask

    initial begin
        pix_t p;
        int   base, b;
        bus.in_valid = 1'b0; bus.in_pix = '0; bus.out_ready = 1'b1;
        bus.w_wr_en = 1'b0; bus.w_wr_ch = '0; bus.w_wr_idx = '0; bus.w_wr_data = '0;

        do_reset(2);

        // Unit weights, saturated pixels: 6375 >>> 8 = 24, three-cycle latency.
        load_all(1, 0);
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        chk("t1_accept", longint'(last_acc), 1);
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk($sformatf("t1_latency_%0d", i), longint'(bus.out_valid), longint'(i == 3));
        end
        drain();
        chk("t1_ch0", ch_of(obs_q[obs_q.size()-1], 0), 24);
        chk("t1_ch2", ch_of(obs_q[obs_q.size()-1], 2), 24);

        // Saturation both ways, ReLU clamp.
        load_all(127, 0);
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        drain();
        chk("t2_pos_sat", ch_of(obs_q[obs_q.size()-1], 1), 2047);
        load_all(-128, 0);
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        drain();
        chk("t2_neg_sat", ch_of(obs_q[obs_q.size()-1], 1), -2048);
        chk("t2_relu", ch_of(obs_r_q[obs_r_q.size()-1], 1), 0);

        // Floor shift, bias write, ignored out-of-range writes.
        do_reset(1);
        wr(0, 0, -1);
        wr(0, TAPS, 5);
        wr(1, TAPS, 7);
        wr(NCH, 0, 100);
        wr(0, TAPS + 2, 100);
        wr(1, (1 << IDXW) - 1, 100);
        p = '0;
        p[DW-1:0] = DW'(1);
        cycle(1'b1, p, 1'b1, 1'b0, 0, 0, 0);
        drain();
        chk("t3_floor", ch_of(obs_q[obs_q.size()-1], 0), 4);
        chk("t3_bias_ch1", ch_of(obs_q[obs_q.size()-1], 1), 7);
        chk("t3_ch2", ch_of(obs_q[obs_q.size()-1], 2), 0);

        // Backpressure: six beats, downstream stalls three cycles mid-stream.
        load_all(3, -20);
        b = 0;
        for (int i = 0; i < 40 && b < 6; i++) begin
            p = pix_all(10 + 37 * b);
            cycle(1'b1, p, !(i >= 4 && i <= 6), 1'b0, 0, 0, 0);
            if (i == 5) chk("t4_in_ready_stall", longint'(bus.in_ready), 0);
            if (last_acc) b++;
        end
        chk("t4_all_accepted", longint'(b), 6);
        drain();

        // Weight change relative to accept.
        load_all(1, 0);
        base = obs_q.size();
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        wr(0, 0, 2);
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        cycle(1'b1, pix_all(255), 1'b1, 1'b1, 0, 0, 3);
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        drain();
        chk("t5_count", longint'(obs_q.size() - base), 4);
        if (obs_q.size() - base == 4) begin
            chk("t5_a_old", ch_of(obs_q[base], 0), 24);
            chk("t5_b_new", ch_of(obs_q[base+1], 0), 25);
            chk("t5_same_cycle_old", ch_of(obs_q[base+2], 0), 25);
            chk("t5_after", ch_of(obs_q[base+3], 0), 26);
        end

        // Randomized traffic with interleaved writes and stalls.
        for (int i = 0; i < 400; i++) begin
            for (int t = 0; t < TAPS; t++)
                p[t*DW +: DW] = DW'(($urandom % 2) ? $urandom_range(0, 255) : $urandom_range(0, 15));
            cycle(($urandom % 4) != 0, p, ($urandom % 4) != 0, ($urandom % 3) == 0,
                  int'($urandom_range(0, NCH)), int'($urandom_range(0, (1 << IDXW) - 1)),
                  int'($urandom_range(0, 255)));
        end
        drain();

        // Reset with beats in flight.
        load_all(2, 9);
        cycle(1'b1, pix_all(200), 1'b1, 1'b0, 0, 0, 0);
        cycle(1'b1, pix_all(100), 1'b1, 1'b0, 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("t6_no_stale", longint'(bus.out_valid), 0);
        end
        base = obs_q.size();
        cycle(1'b1, pix_all(255), 1'b1, 1'b0, 0, 0, 0);
        drain();
        chk("t6_one_out", longint'(obs_q.size() - base), 1);
        chk("t6_cleared", longint'(obs_q[obs_q.size()-1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
